// File: rtl/wca_read_port_burst.sv
// Burst-requesting read port FIFO between the port controller and a local consumer.
// Requests fixed-size bursts from the port controller whenever enough free space exists.
module wca_read_port_burst #(
    parameter int         ADDR_PORT   = 0,
    parameter int         NBITS_ADDR  = 2,
    parameter int         WIDTH       = 32,
    parameter int         DEPTH_LOG2  = 9,
    parameter int         BURST       = 16,
    parameter logic [1:0] PIFCMD_IDLE = 2'd0,
    parameter logic [1:0] PIFCMD_READ = 2'd1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    port_enable,
    input  logic [WIDTH-1:0]        pifData,
    input  logic [NBITS_ADDR+2:0]   portCtrl,
    output logic [1:0]              portCmd,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_out,
    output logic                    rd_valid,
    input  logic [DEPTH_LOG2:0]     thresh_empty,
    input  logic [DEPTH_LOG2:0]     thresh_full,
    output logic [DEPTH_LOG2:0]     level,
    output logic                    empty,
    output logic                    full,
    output logic                    prog_empty,
    output logic                    prog_full,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam int CW    = $clog2(BURST + 1);

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         beat;
    state_t                state;

    logic       is_addr;
    logic       wr_req;
    logic       rd_acc;
    logic       wr_acc;
    logic [LW:0] free;
    logic       unused_rd_bit;

    assign is_addr = portCtrl[NBITS_ADDR+2:2] == (NBITS_ADDR+1)'(ADDR_PORT);
    assign wr_req  = is_addr & portCtrl[0];
    assign unused_rd_bit = portCtrl[1];

    assign empty      = level == '0;
    assign full       = level == LW'(DEPTH);
    assign prog_empty = level <= thresh_empty;
    assign prog_full  = level >= thresh_full;
    assign free       = (LW+1)'(DEPTH) - (LW+1)'(level);

    assign rd_acc = rd_en & port_enable & ~empty;
    // At full a write still lands when a pop frees the head slot on the same edge.
    assign wr_acc = wr_req & (~full | rd_acc);

    assign portCmd = !is_addr ? 2'bzz :
                     (state == ST_BURST) ? PIFCMD_READ : PIFCMD_IDLE;

    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr] <= pifData;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rd_out    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_out <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;
            unique case ({wr_acc, rd_acc})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (wr_req & full & ~rd_acc) overflow <= 1'b1;
            else if (clear_err)          overflow <= 1'b0;
            if (rd_en & port_enable & empty) underflow <= 1'b1;
            else if (clear_err)              underflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else if (!port_enable) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (prog_empty && free >= (LW+1)'(BURST)) state <= ST_BURST;
                end
                ST_BURST: begin
                    if (wr_acc) begin
                        if (beat == CW'(BURST - 1)) begin
                            state <= ST_IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wca_read_port_burst.sv
// Bench for wca_read_port_burst: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wca_read_port_burst;
    localparam int         D      = 512;
    localparam int         B      = 16;
    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_READ = 2'd1;

    logic        clock = 0;
    logic        reset = 1;
    logic        port_enable = 0;
    logic [31:0] pifData = 0;
    logic [4:0]  portCtrl = 0;
    wire  [1:0]  portCmd;
    logic        rd_en = 0;
    logic [31:0] rd_out;
    logic        rd_valid;
    logic [9:0]  thresh_empty = 10'd256;
    logic [9:0]  thresh_full = 10'd400;
    logic [9:0]  level;
    logic        empty, full, prog_empty, prog_full;
    logic        overflow, underflow;
    logic        clear_err = 0;

    wca_read_port_burst #(
        .ADDR_PORT(0), .NBITS_ADDR(2), .WIDTH(32), .DEPTH_LOG2(9), .BURST(B),
        .PIFCMD_IDLE(C_IDLE), .PIFCMD_READ(C_READ)
    ) dut (
        .clock(clock), .reset(reset), .port_enable(port_enable),
        .pifData(pifData), .portCtrl(portCtrl), .portCmd(portCmd),
        .rd_en(rd_en), .rd_out(rd_out), .rd_valid(rd_valid),
        .thresh_empty(thresh_empty), .thresh_full(thresh_full),
        .level(level), .empty(empty), .full(full),
        .prog_empty(prog_empty), .prog_full(prog_full),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, burst request as words still owed.
    logic [31:0] q[$];
    logic [31:0] m_out = 0;
    bit          m_valid = 0;
    bit          m_ovf = 0;
    bit          m_unf = 0;
    bit          m_req = 0;
    int          m_left = 0;

    always @(posedge clock or negedge reset) begin
        int lvl;
        bit wreq, racc, wacc;
        if (!reset) begin
            q.delete();
            m_out = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
            m_req = 0; m_left = 0;
        end else begin
            lvl  = q.size();
            wreq = (portCtrl[4:2] == 3'd0) && portCtrl[0];
            racc = rd_en && port_enable && lvl > 0;
            wacc = wreq && (lvl < D || racc);
            if (wreq && lvl == D && !racc) m_ovf = 1;
            else if (clear_err)            m_ovf = 0;
            if (rd_en && port_enable && lvl == 0) m_unf = 1;
            else if (clear_err)                   m_unf = 0;
            if (!port_enable) m_req = 0;
            else if (!m_req) begin
                if (lvl <= int'(thresh_empty) && D - lvl >= B) begin
                    m_req = 1; m_left = B;
                end
            end else if (wacc) begin
                m_left--;
                if (m_left == 0) m_req = 0;
            end
            if (racc) begin m_out = q.pop_front(); m_valid = 1; end
            else m_valid = 0;
            if (wacc) q.push_back(pifData);
        end
    end

    bit          stream_on = 0;
    logic [31:0] seq_exp = 0;

    always @(negedge clock) begin
        int lvl;
        if (reset) begin
            lvl = q.size();
            check("level", level, lvl);
            check("empty", empty, lvl == 0);
            check("full", full, lvl == D);
            check("prog_empty", prog_empty, lvl <= int'(thresh_empty));
            check("prog_full", prog_full, lvl >= int'(thresh_full));
            check("overflow", overflow, m_ovf);
            check("underflow", underflow, m_unf);
            check("rd_valid", rd_valid, m_valid);
            if (m_valid) check("rd_out", rd_out, m_out);
            if (portCtrl[4:2] == 3'd0)
                check("portCmd", portCmd, m_req ? C_READ : C_IDLE);
            if (stream_on && m_valid) begin
                check("stream_seq", rd_out, seq_exp);
                seq_exp++;
            end
        end
    end

    bit          auto_wr = 0;
    logic [31:0] next_data = 0;
    logic [31:0] last_data = 0;
    int          issued = 0;

    // Acts as the port controller: write one word per cycle while READ is asserted.
    task automatic step();
        @(posedge clock);
        #1;
        if (auto_wr) begin
            if (portCmd == C_READ && next_data <= last_data) begin
                pifData  = next_data;
                next_data++;
                portCtrl = 5'b00001;
                issued++;
            end else begin
                portCtrl = 5'b00000;
            end
        end
        if (stream_on) rd_en = q.size() > 0;
    endtask

    task automatic reset_vals(string tag);
        check({tag, "_level"}, level, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_prog_empty"}, prog_empty, 1);
        check({tag, "_prog_full"}, prog_full, 0);
        check({tag, "_rd_out"}, rd_out, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_portCmd"}, portCmd, C_IDLE);
    endtask

    initial begin
        int cyc;
        port_enable = 1;
        #1 reset = 0;
        #1 reset_vals("rst");
        @(negedge clock);
        #2 reset = 1;

        // First burst straight after reset release.
        next_data = 32'h100;
        last_data = 32'hFFFF_FFFF;
        auto_wr = 1;
        step();
        check("req_after_rst", portCmd, C_READ);
        repeat (16) step();
        check("burst1_done_cmd", portCmd, C_IDLE);
        check("burst1_level", level, 16);
        step();
        check("burst2_req", portCmd, C_READ);

        // Fill to 496 by bursts, then to 500 with requests disabled.
        thresh_empty = 10'd511;
        cyc = 0;
        while (!(q.size() == 496 && portCmd == C_IDLE) && cyc < 2000) begin
            step(); cyc++;
        end
        check("fill496_timeout", cyc < 2000, 1);
        auto_wr = 0;
        port_enable = 0;
        for (int i = 0; i < 4; i++) begin
            portCtrl = 5'b00001;
            pifData  = next_data;
            next_data++;
            step();
        end
        port_enable = 1;
        portCtrl = 5'b01101;
        pifData  = 32'h5555_5555;
        step();
        portCtrl = 5'b00000;
        repeat (3) step();
        check("lvl500_cmd", portCmd, C_IDLE);
        check("lvl500_level", level, 500);
        rd_en = 1;
        repeat (4) step();
        rd_en = 0;
        check("pop4_data", rd_out, 32'h103);
        check("pop4_level", level, 496);
        step();
        check("resume_req", portCmd, C_READ);

        // Fill to full, then overflow and write-with-read at full.
        auto_wr = 1;
        cyc = 0;
        while (!(q.size() == D && portCmd == C_IDLE) && cyc < 100) begin
            step(); cyc++;
        end
        check("fill512_timeout", cyc < 100, 1);
        auto_wr = 0;
        portCtrl = 5'b00001;
        pifData  = 32'hDEAD_0001;
        step();
        portCtrl = 5'b00000;
        check("ovf_flag", overflow, 1);
        check("ovf_level", level, 512);
        portCtrl = 5'b00001;
        pifData  = 32'hBEEF_0002;
        rd_en    = 1;
        step();
        portCtrl = 5'b00000;
        rd_en    = 0;
        check("full_rw_valid", rd_valid, 1);
        check("full_rw_data", rd_out, 32'h104);
        check("full_rw_level", level, 512);

        // Drain, then underflow and clear.
        rd_en = 1;
        cyc = 0;
        while (q.size() != 0 && cyc < 600) begin
            step(); cyc++;
        end
        rd_en = 0;
        check("drain_timeout", cyc < 600, 1);
        rd_en = 1;
        step();
        rd_en = 0;
        check("unf_valid", rd_valid, 0);
        check("unf_flag", underflow, 1);
        clear_err = 1;
        step();
        clear_err = 0;
        check("clr_unf", underflow, 0);
        check("clr_ovf", overflow, 0);

        // Continuous stream across pointer wrap.
        next_data = 32'h1;
        last_data = 32'h600;
        seq_exp   = 32'h1;
        stream_on = 1;
        auto_wr   = 1;
        cyc = 0;
        while (seq_exp <= 32'h600 && cyc < 20000) begin
            step(); cyc++;
        end
        stream_on = 0;
        auto_wr   = 0;
        rd_en     = 0;
        portCtrl  = 5'b00000;
        check("stream_done", seq_exp, 32'h601);
        check("stream_ovf", overflow, 0);
        check("stream_unf", underflow, 0);

        // Mid-burst disable, then asynchronous reset while requesting.
        next_data = 32'h7000;
        last_data = 32'hFFFF_FFFF;
        issued    = 0;
        auto_wr   = 1;
        cyc = 0;
        while (issued < 8 && cyc < 100) begin
            step(); cyc++;
        end
        auto_wr = 0;
        step();
        portCtrl    = 5'b00000;
        port_enable = 0;
        rd_en       = 1;
        step();
        check("dis_cmd", portCmd, C_IDLE);
        check("dis_valid", rd_valid, 0);
        check("dis_level", level, 8);
        rd_en       = 0;
        port_enable = 1;
        step();
        check("rereq_cmd", portCmd, C_READ);
        #2 reset = 0;
        #1 reset_vals("async_rst");
        #20 reset = 1;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wca_read_port_burst.md
# wca_read_port_burst

Single-clock, parametrised successor to the WCA read port: a WIDTH x 2^DEPTH_LOG2 FIFO that is filled by the port controller over the pifData/portCtrl bus and drained by a local consumer. It requests data in fixed BURST-word transactions only when enough free space exists. It adds runtime thresholds, a fill-level output, a registered read-valid and sticky overflow/underflow flags. It sits between the port controller and a DSP/stream consumer in the same clock domain.

## Interface
- ADDR_PORT, 0: port address this instance answers to.
- NBITS_ADDR, 2: port address width minus 1; address field is portCtrl[NBITS_ADDR+2:2].
- WIDTH, 32: data word width.
- DEPTH_LOG2, 9: FIFO depth = 2^DEPTH_LOG2 words.
- BURST, 16: words per port read request; 1 <= BURST <= 2^DEPTH_LOG2.

- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- port_enable  in  1  enables requests and local reads.
- pifData  in  WIDTH  port interface write data.
- portCtrl  in  NBITS_ADDR+3  {addr[NBITS_ADDR:0], read, write}.
- portCmd  out  2  PIFCMD_READ / PIFCMD_IDLE when addressed, else high-Z.
- rd_en  in  1  local read request.
- rd_out  out  WIDTH  read data, registered.
- rd_valid  out  1  rd_out holds a word popped on the previous edge.
- thresh_empty  in  DEPTH_LOG2+1  prog_empty threshold.
- thresh_full  in  DEPTH_LOG2+1  prog_full threshold.
- level  out  DEPTH_LOG2+1  current word count, 0..2^DEPTH_LOG2.
- empty, full  out  1  level==0 / level==2^DEPTH_LOG2.
- prog_empty, prog_full  out  1  level<=thresh_empty / level>=thresh_full.
- overflow, underflow  out  1  sticky error flags.
- clear_err  in  1  synchronous clear of overflow/underflow.

## Operation
- isAddr = (portCtrl[NBITS_ADDR+2:2] == ADDR_PORT); wr_req = isAddr & portCtrl[0].
- Write accepted iff wr_req & (!full | rd_acc). Writes are accepted regardless of port_enable, so in-flight burst data is not lost.
- rd_acc = rd_en & port_enable & !empty. Pops the head word into rd_out; rd_valid=1 next cycle, else rd_valid=0 and rd_out holds its value.
- Simultaneous accepted write and read: level unchanged; at full, both are accepted.
- Write with wr_req & full & !rd_acc: word dropped, overflow<=1. rd_en & port_enable & empty: no pop, underflow<=1. Flags stay set until clear_err or reset; an error event coincident with clear_err sets the flag.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. level is a separate up/down counter.
- empty, full, prog_empty and prog_full are combinational from the level register, with no extra latency.
- Request FSM, states IDLE and BURST:
  - IDLE -> BURST when port_enable & prog_empty & (2^DEPTH_LOG2 - level >= BURST).
  - BURST: count accepted writes in a counter cleared on entry. On the accepted write that makes count==BURST -> IDLE. The FSM stays in IDLE at least one cycle before re-requesting.
  - port_enable low in any state -> IDLE next edge; counter cleared.
- portCmd: high-Z when !isAddr; PIFCMD_READ when isAddr & state==BURST; otherwise PIFCMD_IDLE. The PIFCMD encodings are from WcaPortDefs.h.
- portCtrl read bit is ignored.

## Timing
- Reset values (asynchronous on reset low): pointers 0, level 0, empty=1, full=0, prog_empty=1, prog_full=(thresh_full==0), rd_out=0, rd_valid=0, overflow=0, underflow=0, FSM=IDLE, burst counter 0.
- Reset asserted mid-burst: contents discarded and FSM in IDLE immediately. After release, the first request may occur on the first edge on which the IDLE exit condition holds.
- Write at edge N: level and flags update after N; the word is poppable by rd_en sampled at edge N+1. rd_out/rd_valid are valid after N+1.
- Read latency: 1 clock from sampled rd_en to rd_out/rd_valid.
- portCmd reacts combinationally to the address; the state changes on the edge after the last burst word, so portCmd is IDLE in the cycle following that word.
- Threshold inputs are sampled continuously; a change takes effect on flags immediately and on the FSM at the next edge.

## Test plan
- Reset, DEPTH_LOG2=9, BURST=16, thresh_empty=256, port_enable=1 -> the cycle after release: FSM BURST, addressed portCmd=PIFCMD_READ; after 16 writes portCmd=PIFCMD_IDLE for ≥1 cycle, then READ again; level=16.
- Fill to 500 with no reads, thresh_empty=511 -> no request, since free=12<16; pop 4 words (level 496) -> request resumes.
- Fill to 512, then write with no read -> word dropped, overflow=1, level=512. Write with rd_en in the same cycle -> level stays 512, overflow unchanged, rd_valid=1 next cycle with the oldest word.
- Empty FIFO, rd_en=1 -> rd_valid=0, underflow=1; clear_err pulse -> underflow=0.
- Write 0x00000001..0x00000600 through repeated bursts while reading continuously -> rd_out sequence in order across pointer wrap; no overflow or underflow.
- Mid-burst (8 of 16 words): drop port_enable -> portCmd=PIFCMD_IDLE next cycle and rd_en ignored. Then assert reset low -> all outputs at reset values immediately, with no clock edge required.
